cmp_sched: RTL and testbench
============================

# cmp_sched

Scheduler that shares the single 32-bit `cmp` comparator between two requesters: the branch unit (branch resolution) and the ALU set-less-than path (SLT/SLTI/SLTU/SLTIU). It arbitrates requests, registers the operands, drives the comparator, and returns each result to its owner over a valid/ready response channel. It sits between decode/execute issue and the comparator in the execute stage, and gives one compare per cycle of throughput with 2-cycle latency.

## Interface
- `XLEN`, 32, operand width; only 32 is supported (comparator width).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  kill all in-flight compares (pipeline redirect).
- `br_req_valid`  in  1  branch request valid.
- `br_req_ready`  out  1  branch request accepted this cycle if valid.
- `br_a`, `br_b`  in  XLEN  branch operands.
- `br_mode`  in  3  comparator mode (funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU).
- `br_rsp_valid`  out  1  branch result valid.
- `br_rsp_ready`  in  1  branch unit consumes result.
- `br_rsp_q`  out  1  branch taken.
- `alu_req_valid`, `alu_req_ready`, `alu_a`, `alu_b`, `alu_mode`  same as the branch request signals; mode 010 LT, 011 LTU.
- `alu_rsp_valid`, `alu_rsp_ready`, `alu_rsp_q`  same as the branch response signals.

## Operation
- Two-stage pipe: S1 (operand/mode/owner register, `s1_vld`) and S2 (result/owner register, `s2_vld`). The comparator is combinational on the S1 contents.
- S2 drains when `s2_vld` and the owner's `rsp_ready` are both high. S1 advances when `!s2_vld` or S2 drains. The pipe accepts when `!s1_vld` or S1 advances.
- Grant is combinational: `x_req_ready` = accept && !flush && rst_n && granted(x).
  - A requester is granted when it is valid and either the other is not valid or it wins priority.
  - A ready high while the requester's own valid is low has no effect.
- Requesters hold valid and payload stable until accepted. Modes are passed through unchecked.
- The response is presented only on the owner's channel; the other channel's `rsp_valid` is 0. `rsp_q` holds its value while `rsp_valid` is high and not consumed.
- Flush: at the clock edge, `s1_vld` and `s2_vld` are cleared; no request is accepted in that cycle.
  - A response handshake completing in the flush cycle counts as delivered.
  - Killed compares produce no response.
- Reset (asynchronous): `s1_vld`=0, `s2_vld`=0, result 0, owner 0, round-robin pointer set so the branch unit wins first. All `*_rsp_valid`/`*_rsp_q` are 0; all `*_req_ready` are 0 while `rst_n`=0.
- Reset asserted mid-operation discards all in-flight compares with no responses.

## Timing
- Request accepted at edge N → S1 at N → result registered at N+1 → `rsp_valid` high in cycle N+1..N+2. Latency 2 cycles.
- Throughput: 1 accepted request per cycle while the consumer holds `rsp_ready` high.
- Backpressure: with S2 held, S1 holds, and one more request may still fill an empty S1; then both readies are 0.
- Simultaneous S2 drain and S1 advance in the same cycle are required (no bubble).

## Configuration
- `CMP_SCHED_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on every accepted request.
  - On a conflict, the requester not granted last wins.
- Not defined: fixed priority, branch unit always wins conflicts, no pointer state. The ALU requester can starve; this is acceptable because the branch unit issues at most every other cycle.

## Structure
- Shared package/header `cmp_pkg`:
  - mode constants `CMP_EQ`=3'b000, `CMP_NE`=3'b001, `CMP_SLT`=3'b010, `CMP_SLTU`=3'b011, `CMP_LT`=3'b100, `CMP_GE`=3'b101, `CMP_LTU`=3'b110, `CMP_GEU`=3'b111;
  - owner encoding `OWN_BR`=1'b0, `OWN_ALU`=1'b1.
- One sub-module: the existing `cmp` comparator, instantiated once on the S1 operands. Arbiter and pipe logic are inline.

## Test plan
- Single branch request, a=5, b=5, mode 000 → `br_rsp_valid` 2 cycles later, `br_rsp_q`=1; `alu_rsp_valid` stays 0.
- ALU request, a=32'hFFFF_FFFF, b=1, mode 010 → q=1; same operands with mode 011 → q=0.
- Both requesters valid every cycle, responses always ready:
  - with `CMP_SCHED_RR_EN`, grants alternate BR, ALU, BR, ALU, ...;
  - without it, all grants go to BR and ALU starves.
- `br_rsp_ready` held 0 for 4 cycles with 3 back-to-back requests → S2 and S1 fill, readies drop to 0, no result lost or reordered after release.
- `flush` asserted with both stages full → both `rsp_valid` are 0 next cycle and no late responses appear; a request valid in the flush cycle is accepted in the following cycle.
- `rst_n` pulsed low mid-stream → all outputs 0 immediately; after release the branch unit wins the first conflict.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared comparator definitions: funct3-style mode codes and result-owner encoding.
package cmp_pkg;

  localparam logic [2:0] CMP_EQ   = 3'b000;
  localparam logic [2:0] CMP_NE   = 3'b001;
  localparam logic [2:0] CMP_SLT  = 3'b010;
  localparam logic [2:0] CMP_SLTU = 3'b011;
  localparam logic [2:0] CMP_LT   = 3'b100;
  localparam logic [2:0] CMP_GE   = 3'b101;
  localparam logic [2:0] CMP_LTU  = 3'b110;
  localparam logic [2:0] CMP_GEU  = 3'b111;

  localparam logic OWN_BR  = 1'b0;
  localparam logic OWN_ALU = 1'b1;

endpackage

// File: rtl/cmp.sv
// Combinational 32-bit comparator serving both branch conditions and set-less-than.
module cmp
  import cmp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      mode,
  output logic            q
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    q = 1'b0;
    case (mode)
      CMP_EQ:          q = (a == b);
      CMP_NE:          q = (a != b);
      CMP_SLT, CMP_LT: q = lt_s;
      CMP_GE:          q = !lt_s;
      CMP_SLTU, CMP_LTU: q = lt_u;
      CMP_GEU:         q = !lt_u;
      default:         q = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_sched.sv
// Two-requester scheduler for the shared comparator: arbiter, S1 operand stage, S2 result stage.
// Define CMP_SCHED_RR_EN for round-robin arbitration; otherwise the branch unit has fixed priority.
module cmp_sched
  import cmp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            br_req_valid,
  output logic            br_req_ready,
  input  logic [XLEN-1:0] br_a,
  input  logic [XLEN-1:0] br_b,
  input  logic [2:0]      br_mode,
  output logic            br_rsp_valid,
  input  logic            br_rsp_ready,
  output logic            br_rsp_q,
  input  logic            alu_req_valid,
  output logic            alu_req_ready,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [2:0]      alu_mode,
  output logic            alu_rsp_valid,
  input  logic            alu_rsp_ready,
  output logic            alu_rsp_q
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the sender holds valid and payload stable until then, ready never depends on a later cycle.

  logic            s1_vld;
  logic [XLEN-1:0] s1_a;
  logic [XLEN-1:0] s1_b;
  logic [2:0]      s1_mode;
  logic            s1_own;
  logic            s2_vld;
  logic            s2_q;
  logic            s2_own;

  logic cmp_q;
  logic s2_drain;
  logic s1_adv;
  logic accept;
  logic go;
  logic br_wins;
  logic take;

  cmp #(.XLEN(XLEN)) u_cmp (
    .a    (s1_a),
    .b    (s1_b),
    .mode (s1_mode),
    .q    (cmp_q)
  );

  assign s2_drain = s2_vld && ((s2_own == OWN_ALU) ? alu_rsp_ready : br_rsp_ready);
  assign s1_adv   = s1_vld && (!s2_vld || s2_drain);
  assign accept   = !s1_vld || s1_adv;
  assign go       = accept && !flush && rst_n;

  assign br_req_ready  = go && br_req_valid && (!alu_req_valid || br_wins);
  assign alu_req_ready = go && alu_req_valid && (!br_req_valid || !br_wins);
  assign take          = br_req_ready || alu_req_ready;

`ifdef CMP_SCHED_RR_EN
  logic last_own;

  // Reset value makes the branch unit the winner of the first conflict.
  assign br_wins = (last_own == OWN_ALU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_own <= OWN_ALU;
    end else if (take) begin
      last_own <= alu_req_ready ? OWN_ALU : OWN_BR;
    end
  end
`else
  assign br_wins = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= CMP_EQ;
      s1_own  <= OWN_BR;
      s2_vld  <= 1'b0;
      s2_q    <= 1'b0;
      s2_own  <= OWN_BR;
    end else if (flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_vld <= 1'b1;
        s2_q   <= cmp_q;
        s2_own <= s1_own;
      end else if (s2_drain) begin
        s2_vld <= 1'b0;
      end

      if (take) begin
        s1_vld  <= 1'b1;
        s1_a    <= br_req_ready ? br_a    : alu_a;
        s1_b    <= br_req_ready ? br_b    : alu_b;
        s1_mode <= br_req_ready ? br_mode : alu_mode;
        s1_own  <= br_req_ready ? OWN_BR  : OWN_ALU;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
    end
  end

  assign br_rsp_valid  = s2_vld && (s2_own == OWN_BR);
  assign alu_rsp_valid = s2_vld && (s2_own == OWN_ALU);
  assign br_rsp_q      = br_rsp_valid && s2_q;
  assign alu_rsp_q     = alu_rsp_valid && s2_q;

endmodule

// File: tb/tb_cmp_sched.sv
// Directed bench for cmp_sched: single compares, arbitration, backpressure, flush, async reset.
module tb_cmp_sched;
  import cmp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        br_req_valid;
  logic        br_req_ready;
  logic [31:0] br_a;
  logic [31:0] br_b;
  logic [2:0]  br_mode;
  logic        br_rsp_valid;
  logic        br_rsp_ready;
  logic        br_rsp_q;
  logic        alu_req_valid;
  logic        alu_req_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_mode;
  logic        alu_rsp_valid;
  logic        alu_rsp_ready;
  logic        alu_rsp_q;

  int checks;
  int failures;
  logic [1:0] exp_q[$];

  cmp_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .br_req_valid  (br_req_valid),
    .br_req_ready  (br_req_ready),
    .br_a          (br_a),
    .br_b          (br_b),
    .br_mode       (br_mode),
    .br_rsp_valid  (br_rsp_valid),
    .br_rsp_ready  (br_rsp_ready),
    .br_rsp_q      (br_rsp_q),
    .alu_req_valid (alu_req_valid),
    .alu_req_ready (alu_req_ready),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_mode      (alu_mode),
    .alu_rsp_valid (alu_rsp_valid),
    .alu_rsp_ready (alu_rsp_ready),
    .alu_rsp_q     (alu_rsp_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_req_valid  = 1'b0;
    alu_req_valid = 1'b0;
    br_rsp_ready  = 1'b1;
    alu_rsp_ready = 1'b1;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    br_req_valid = 1'b1;
    alu_req_valid = 1'b1;
    #1;
    checks++; if (br_req_ready !== 1'b0) begin failures++; $display("FAIL reset_br_req_ready got=%b exp=0", br_req_ready); end
    checks++; if (alu_req_ready !== 1'b0) begin failures++; $display("FAIL reset_alu_req_ready got=%b exp=0", alu_req_ready); end
    checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_br_rsp_valid got=%b exp=0", br_rsp_valid); end
    checks++; if (alu_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_alu_rsp_valid got=%b exp=0", alu_rsp_valid); end
    checks++; if (br_rsp_q !== 1'b0) begin failures++; $display("FAIL reset_br_rsp_q got=%b exp=0", br_rsp_q); end
    checks++; if (alu_rsp_q !== 1'b0) begin failures++; $display("FAIL reset_alu_rsp_q got=%b exp=0", alu_rsp_q); end
    cycle();
    cycle();
    idle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_branch();
    logic [31:0] va[6];
    logic [31:0] vb[6];
    logic [2:0]  vm[6];
    logic        ve[6];
    va[0] = 32'd5;         vb[0] = 32'd5; vm[0] = CMP_EQ;  ve[0] = 1'b1;
    va[1] = 32'd5;         vb[1] = 32'd6; vm[1] = CMP_NE;  ve[1] = 1'b1;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'd1; vm[2] = CMP_LT;  ve[2] = 1'b1;
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'd1; vm[3] = CMP_GE;  ve[3] = 1'b0;
    va[4] = 32'hFFFF_FFFF; vb[4] = 32'd1; vm[4] = CMP_LTU; ve[4] = 1'b0;
    va[5] = 32'hFFFF_FFFF; vb[5] = 32'd1; vm[5] = CMP_GEU; ve[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      br_req_valid = 1'b1; br_a = va[i]; br_b = vb[i]; br_mode = vm[i];
      #1;
      checks++; if (br_req_ready !== 1'b1) begin failures++; $display("FAIL br_req_ready[%0d] got=%b exp=1", i, br_req_ready); end
      cycle();
      br_req_valid = 1'b0;
      #1;
      checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL br_early_rsp[%0d] got=%b exp=0", i, br_rsp_valid); end
      cycle();
      checks++; if (br_rsp_valid !== 1'b1) begin failures++; $display("FAIL br_rsp_valid[%0d] got=%b exp=1", i, br_rsp_valid); end
      checks++; if (br_rsp_q !== ve[i]) begin failures++; $display("FAIL br_rsp_q[%0d] got=%b exp=%b", i, br_rsp_q, ve[i]); end
      checks++; if (alu_rsp_valid !== 1'b0) begin failures++; $display("FAIL br_alu_quiet[%0d] got=%b exp=0", i, alu_rsp_valid); end
      cycle();
      checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL br_drained[%0d] got=%b exp=0", i, br_rsp_valid); end
    end
  endtask

  task automatic test_alu();
    logic [31:0] va[3];
    logic [31:0] vb[3];
    logic [2:0]  vm[3];
    logic        ve[3];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;         vm[0] = CMP_SLT;  ve[0] = 1'b1;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1;         vm[1] = CMP_SLTU; ve[1] = 1'b0;
    va[2] = 32'd1;         vb[2] = 32'hFFFF_FFFF; vm[2] = CMP_SLTU; ve[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_req_valid = 1'b1; alu_a = va[i]; alu_b = vb[i]; alu_mode = vm[i];
      #1;
      checks++; if (alu_req_ready !== 1'b1) begin failures++; $display("FAIL alu_req_ready[%0d] got=%b exp=1", i, alu_req_ready); end
      cycle();
      alu_req_valid = 1'b0;
      cycle();
      checks++; if (alu_rsp_valid !== 1'b1) begin failures++; $display("FAIL alu_rsp_valid[%0d] got=%b exp=1", i, alu_rsp_valid); end
      checks++; if (alu_rsp_q !== ve[i]) begin failures++; $display("FAIL alu_rsp_q[%0d] got=%b exp=%b", i, alu_rsp_q, ve[i]); end
      checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL alu_br_quiet[%0d] got=%b exp=0", i, br_rsp_valid); end
      cycle();
    end
  endtask

  task automatic test_arbitration();
    logic exp_br;
    logic [1:0] got;
    logic [1:0] exp;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    br_a = 32'd1;  br_b = 32'd2;  br_mode = CMP_LT;    // q = 1
    alu_a = 32'd3; alu_b = 32'd2; alu_mode = CMP_SLT;  // q = 0
    br_req_valid = 1'b1;
    alu_req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i >= 8) begin
        br_req_valid = 1'b0;
        alu_req_valid = 1'b0;
      end
      #1;
      if (i < 8) begin
`ifdef CMP_SCHED_RR_EN
        exp_br = (i % 2 == 0);
`else
        exp_br = 1'b1;
`endif
        checks++; if (br_req_ready !== exp_br) begin failures++; $display("FAIL arb_br_grant[%0d] got=%b exp=%b", i, br_req_ready, exp_br); end
        checks++; if (alu_req_ready !== !exp_br) begin failures++; $display("FAIL arb_alu_grant[%0d] got=%b exp=%b", i, alu_req_ready, !exp_br); end
        if (br_req_ready) exp_q.push_back({OWN_BR, 1'b1});
        if (alu_req_ready) exp_q.push_back({OWN_ALU, 1'b0});
      end
      if (br_rsp_valid && alu_rsp_valid) begin
        checks++; failures++; $display("FAIL arb_both_rsp[%0d] got=11 exp=one", i);
      end else if (br_rsp_valid || alu_rsp_valid) begin
        got = br_rsp_valid ? {OWN_BR, br_rsp_q} : {OWN_ALU, alu_rsp_q};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        checks++; if (got !== exp) begin failures++; $display("FAIL arb_rsp[%0d] got=%b exp=%b", i, got, exp); end
      end
      cycle();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL arb_lost got=%0d exp=0 pending", exp_q.size()); exp_q.delete(); end
    idle();
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[3];
    logic [31:0] vb[3];
    logic [9:0]  rdy_v;
    logic [9:0]  rv_v;
    logic [1:0]  exp;
    int idx;
    va[0] = 32'd1; vb[0] = 32'd1;  // EQ -> 1
    va[1] = 32'd1; vb[1] = 32'd2;  // EQ -> 0
    va[2] = 32'd3; vb[2] = 32'd3;  // EQ -> 1
    rdy_v = 10'b0000010011;
    rv_v  = 10'b0001111100;
    idx = 0;
    br_mode = CMP_EQ;
    for (int c = 0; c < 10; c++) begin
      br_rsp_ready = (c >= 4);
      br_req_valid = (idx < 3);
      if (idx < 3) begin br_a = va[idx]; br_b = vb[idx]; end
      #1;
      checks++; if (br_req_ready !== rdy_v[c]) begin failures++; $display("FAIL bp_req_ready[%0d] got=%b exp=%b", c, br_req_ready, rdy_v[c]); end
      checks++; if (br_rsp_valid !== rv_v[c]) begin failures++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=%b", c, br_rsp_valid, rv_v[c]); end
      if (br_rsp_valid) begin
        exp = (exp_q.size() > 0) ? exp_q[0] : 2'bxx;
        checks++; if ({OWN_BR, br_rsp_q} !== exp) begin failures++; $display("FAIL bp_rsp_q[%0d] got=%b exp=%b", c, br_rsp_q, exp[0]); end
        if (br_rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (br_req_valid && br_req_ready) begin
        exp_q.push_back({OWN_BR, va[idx] == vb[idx]});
        idx++;
      end
      cycle();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_lost got=%0d exp=0 pending", exp_q.size()); exp_q.delete(); end
    idle();
  endtask

  task automatic test_flush();
    br_rsp_ready = 1'b0;
    br_mode = CMP_EQ;
    br_req_valid = 1'b1; br_a = 32'd7; br_b = 32'd7;
    #1;
    checks++; if (br_req_ready !== 1'b1) begin failures++; $display("FAIL fl_req0 got=%b exp=1", br_req_ready); end
    cycle();
    br_a = 32'd7; br_b = 32'd8;
    #1;
    checks++; if (br_req_ready !== 1'b1) begin failures++; $display("FAIL fl_req1 got=%b exp=1", br_req_ready); end
    cycle();
    flush = 1'b1; br_rsp_ready = 1'b1; br_a = 32'd9; br_b = 32'd9;
    #1;
    checks++; if (br_req_ready !== 1'b0) begin failures++; $display("FAIL fl_blocked got=%b exp=0", br_req_ready); end
    checks++; if (br_rsp_valid !== 1'b1) begin failures++; $display("FAIL fl_last_rsp got=%b exp=1", br_rsp_valid); end
    checks++; if (br_rsp_q !== 1'b1) begin failures++; $display("FAIL fl_last_q got=%b exp=1", br_rsp_q); end
    cycle();
    flush = 1'b0;
    #1;
    checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL fl_br_killed got=%b exp=0", br_rsp_valid); end
    checks++; if (alu_rsp_valid !== 1'b0) begin failures++; $display("FAIL fl_alu_killed got=%b exp=0", alu_rsp_valid); end
    checks++; if (br_req_ready !== 1'b1) begin failures++; $display("FAIL fl_req_after got=%b exp=1", br_req_ready); end
    cycle();
    br_req_valid = 1'b0;
    #1;
    checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL fl_no_late got=%b exp=0", br_rsp_valid); end
    cycle();
    checks++; if (br_rsp_valid !== 1'b1) begin failures++; $display("FAIL fl_new_rsp got=%b exp=1", br_rsp_valid); end
    checks++; if (br_rsp_q !== 1'b1) begin failures++; $display("FAIL fl_new_q got=%b exp=1", br_rsp_q); end
    cycle();
    checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL fl_drained got=%b exp=0", br_rsp_valid); end
    idle();
  endtask

  task automatic test_reset_mid();
    logic exp_second_alu;
`ifdef CMP_SCHED_RR_EN
    exp_second_alu = 1'b1;
`else
    exp_second_alu = 1'b0;
`endif
    br_a = 32'd1;  br_b = 32'd2;  br_mode = CMP_LT;    // q = 1
    alu_a = 32'd3; alu_b = 32'd2; alu_mode = CMP_SLT;  // q = 0
    br_req_valid = 1'b1;
    alu_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (br_req_ready !== 1'b0) begin failures++; $display("FAIL rm_br_req_ready got=%b exp=0", br_req_ready); end
    checks++; if (alu_req_ready !== 1'b0) begin failures++; $display("FAIL rm_alu_req_ready got=%b exp=0", alu_req_ready); end
    checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_br_rsp_valid got=%b exp=0", br_rsp_valid); end
    checks++; if (alu_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_alu_rsp_valid got=%b exp=0", alu_rsp_valid); end
    checks++; if (br_rsp_q !== 1'b0) begin failures++; $display("FAIL rm_br_rsp_q got=%b exp=0", br_rsp_q); end
    cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (br_req_ready !== 1'b1) begin failures++; $display("FAIL rm_first_br got=%b exp=1", br_req_ready); end
    checks++; if (alu_req_ready !== 1'b0) begin failures++; $display("FAIL rm_first_alu got=%b exp=0", alu_req_ready); end
    checks++; if (br_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_stale got=%b exp=0", br_rsp_valid); end
    cycle();
    checks++; if (alu_req_ready !== exp_second_alu) begin failures++; $display("FAIL rm_second_alu got=%b exp=%b", alu_req_ready, exp_second_alu); end
    cycle();
    br_req_valid = 1'b0;
    alu_req_valid = 1'b0;
    #1;
    checks++; if (br_rsp_valid !== 1'b1) begin failures++; $display("FAIL rm_rsp1_valid got=%b exp=1", br_rsp_valid); end
    checks++; if (br_rsp_q !== 1'b1) begin failures++; $display("FAIL rm_rsp1_q got=%b exp=1", br_rsp_q); end
    cycle();
    checks++; if (alu_rsp_valid !== exp_second_alu) begin failures++; $display("FAIL rm_rsp2_alu got=%b exp=%b", alu_rsp_valid, exp_second_alu); end
    checks++; if (br_rsp_valid !== !exp_second_alu) begin failures++; $display("FAIL rm_rsp2_br got=%b exp=%b", br_rsp_valid, !exp_second_alu); end
    cycle();
    checks++; if (br_rsp_valid !== 1'b0 || alu_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_empty got=%b%b exp=00", br_rsp_valid, alu_rsp_valid); end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle();
    br_a = '0; br_b = '0; br_mode = CMP_EQ;
    alu_a = '0; alu_b = '0; alu_mode = CMP_SLT;
    test_reset();
    test_branch();
    test_alu();
    test_arbitration();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
